// File: rtl/led_panel_pkg.sv
// Shared definitions for the LED panel UART command protocol: operation
// encodings, command byte values, state enums and the byte encoders.
// Used by both the host-side transmitter and the panel receiver side.
package led_panel_pkg;

  localparam logic [1:0] OP_COLOUR = 2'b00;
  localparam logic [1:0] OP_SET    = 2'b01;
  localparam logic [1:0] OP_CLR    = 2'b10;
  localparam logic [1:0] OP_CLS    = 2'b11;

  localparam logic [7:0] CMD_COLOUR = 8'h00;
  localparam logic [7:0] CMD_SET    = 8'h10;
  localparam logic [7:0] CMD_CLR    = 8'h20;
  localparam logic [7:0] CMD_CLS    = 8'h30;
  localparam logic [7:0] CMD_SYNC   = 8'hFF;

  // Transmit controller states; SYNC exists only when the resync prefix is built in.
  typedef enum logic [1:0] {
    ST_IDLE,
`ifdef LED_CMD_TX_RESYNC_EN
    ST_SYNC,
`endif
    ST_CMD,
    ST_ARG
  } ctrl_state_t;

  // Byte-level serializer states.
  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP,
    TX_GAP
  } tx_state_t;

  // First command byte for an operation; the colour is carried only by OP_COLOUR.
  function automatic logic [7:0] encode_cmd(input logic [1:0] op, input logic [2:0] rgb);
    logic [7:0] b;
    case (op)
      OP_COLOUR: b = CMD_COLOUR | {5'b0, rgb};
      OP_SET:    b = CMD_SET;
      OP_CLR:    b = CMD_CLR;
      default:   b = CMD_CLS;
    endcase
    return b;
  endfunction

  // Pixel argument byte; bit 3 is always zero so it can never alias CMD_SYNC.
  function automatic logic [7:0] encode_arg(input logic [3:0] col, input logic [2:0] row);
    return {col, 1'b0, row};
  endfunction

  function automatic logic op_has_arg(input logic [1:0] op);
    return (op == OP_SET) || (op == OP_CLR);
  endfunction

endpackage

// File: rtl/led_panel_cmd_tx_uart_tx.sv
// Byte-level 8N1 serializer: START(0), 8 data bits LSB first, STOP(1), then an
// optional idle-high gap. done pulses during the final stop/gap cycle, and a new
// start is accepted in that same cycle so bytes can run back-to-back.
module led_panel_cmd_tx_uart_tx
  import led_panel_pkg::*;
#(
  parameter int CLKS_PER_BIT = 20,
  parameter int GAP_BITS     = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int GAP_MULT = (GAP_BITS > 0) ? GAP_BITS : 1;
  localparam int CW       = $clog2(CLKS_PER_BIT * GAP_MULT);
  localparam int GAP_CYC  = GAP_BITS * CLKS_PER_BIT;
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] GAP_LAST = (GAP_BITS > 0) ? CW'(GAP_CYC - 1) : '0;

  tx_state_t      state, state_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic [2:0]     idx, idx_n;
  logic [7:0]     shreg, shreg_n;

  // Control state and counters are reset; the shift register carries data only.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= TX_IDLE;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
    end
    shreg <= shreg_n;
  end

  // Bit timing and frame sequencing; a start in IDLE or on the done cycle loads a new byte.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    shreg_n = shreg;
    done    = 1'b0;
    case (state)
      TX_START: begin
        if (cnt == BIT_LAST) begin
          cnt_n   = '0;
          idx_n   = '0;
          state_n = TX_DATA;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      TX_DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_n   = '0;
          shreg_n = {1'b0, shreg[7:1]};
          if (idx == 3'd7) state_n = TX_STOP;
          else             idx_n   = idx + 3'd1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      TX_STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_n = '0;
          if (GAP_BITS == 0) begin
            done    = 1'b1;
            state_n = TX_IDLE;
          end else begin
            state_n = TX_GAP;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      TX_GAP: begin
        if (cnt == GAP_LAST) begin
          cnt_n   = '0;
          done    = 1'b1;
          state_n = TX_IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: ;
    endcase
    if (start && ((state == TX_IDLE) || done)) begin
      state_n = TX_START;
      cnt_n   = '0;
      shreg_n = data;
    end
  end

  assign tx   = (state == TX_START) ? 1'b0 :
                (state == TX_DATA)  ? shreg[0] : 1'b1;
  assign busy = (state != TX_IDLE);

endmodule

// File: rtl/led_panel_cmd_tx.sv
// Host-side LED panel command transmitter: accepts one command per valid/ready
// handshake, encodes it into 1-2 bytes and hands them to the 8N1 serializer.
// Optional macro LED_CMD_TX_RESYNC_EN prefixes every command with CMD_SYNC.
module led_panel_cmd_tx
  import led_panel_pkg::*;
#(
  parameter int CLKS_PER_BIT = 20,
  parameter int GAP_BITS     = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [2:0] cmd_rgb,
  input  logic [3:0] cmd_col,
  input  logic [2:0] cmd_row,
  output logic       uart_tx_out,
  output logic       busy
);

  ctrl_state_t state, state_n;
  logic        accept;
  logic [7:0]  cmd_byte;
  logic [7:0]  arg_byte;
  logic        has_arg;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic        tx_done;

  // Ready is forced low while reset is held so nothing is accepted during reset.
  assign cmd_ready = (state == ST_IDLE) && !reset;
  assign accept    = cmd_valid && cmd_ready;
  assign busy      = (state != ST_IDLE) || tx_busy;

  // Controller state register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_n;
  end

  // Capture the encoded command at the accept edge; later inputs are ignored.
  always_ff @(posedge clk) begin
    if (accept) begin
      cmd_byte <= encode_cmd(cmd_op, cmd_rgb);
      arg_byte <= encode_arg(cmd_col, cmd_row);
      has_arg  <= op_has_arg(cmd_op);
    end
  end

  // Byte sequencing: the first byte is launched straight from the inputs on the
  // accept edge, each following byte on the serializer's done cycle.
  always_comb begin
    state_n  = state;
    tx_start = 1'b0;
    tx_data  = cmd_byte;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          tx_start = 1'b1;
`ifdef LED_CMD_TX_RESYNC_EN
          tx_data  = CMD_SYNC;
          state_n  = ST_SYNC;
`else
          tx_data  = encode_cmd(cmd_op, cmd_rgb);
          state_n  = ST_CMD;
`endif
        end
      end
`ifdef LED_CMD_TX_RESYNC_EN
      ST_SYNC: begin
        if (tx_done) begin
          tx_start = 1'b1;
          tx_data  = cmd_byte;
          state_n  = ST_CMD;
        end
      end
`endif
      ST_CMD: begin
        if (tx_done) begin
          if (has_arg) begin
            tx_start = 1'b1;
            tx_data  = arg_byte;
            state_n  = ST_ARG;
          end else begin
            state_n  = ST_IDLE;
          end
        end
      end
      ST_ARG: begin
        if (tx_done) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  led_panel_cmd_tx_uart_tx #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .GAP_BITS     (GAP_BITS)
  ) u_uart_tx (
    .clk   (clk),
    .reset (reset),
    .start (tx_start),
    .data  (tx_data),
    .tx    (uart_tx_out),
    .busy  (tx_busy),
    .done  (tx_done)
  );

endmodule

// File: tb/tb_led_panel_cmd_tx.sv
// Directed bench for led_panel_cmd_tx: two instances (GAP_BITS 0 and 2), line
// captured cycle by cycle and compared against hand-encoded frames.
module tb_led_panel_cmd_tx;

  localparam int CPB = 20;
`ifdef LED_CMD_TX_RESYNC_EN
  localparam int RS = 1;
`else
  localparam int RS = 0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid, cmd_ready, uart_tx_out, busy;
  logic [1:0] cmd_op;
  logic [2:0] cmd_rgb, cmd_row;
  logic [3:0] cmd_col;
  logic       g_valid, g_ready, g_tx, g_busy;
  logic [1:0] g_op;
  logic [2:0] g_rgb, g_row;
  logic [3:0] g_col;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  led_panel_cmd_tx #(.CLKS_PER_BIT(CPB), .GAP_BITS(0)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_rgb(cmd_rgb), .cmd_col(cmd_col), .cmd_row(cmd_row),
    .uart_tx_out(uart_tx_out), .busy(busy));

  led_panel_cmd_tx #(.CLKS_PER_BIT(CPB), .GAP_BITS(2)) dut_gap (
    .clk(clk), .reset(reset), .cmd_valid(g_valid), .cmd_ready(g_ready),
    .cmd_op(g_op), .cmd_rgb(g_rgb), .cmd_col(g_col), .cmd_row(g_row),
    .uart_tx_out(g_tx), .busy(g_busy));

  // Expected 10-bit line frame, bit 0 first on the wire.
  function automatic logic [9:0] fr10(input logic [7:0] b);
    return {1'b1, b, 1'b0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a command and return once it has been accepted (caller sits at cycle 1 of the frame).
  task automatic send(input bit g, input logic [1:0] op, input logic [2:0] rgb,
                      input logic [3:0] col, input logic [2:0] row, output bit ok);
    int n;
    n  = 0;
    ok = 1'b0;
    if (g) begin g_op = op; g_rgb = rgb; g_col = col; g_row = row; g_valid = 1'b1; end
    else   begin cmd_op = op; cmd_rgb = rgb; cmd_col = col; cmd_row = row; cmd_valid = 1'b1; end
    while (n < 1000 && !ok) begin
      ok = g ? g_ready : cmd_ready;
      tick();
      n++;
    end
    if (g) g_valid = 1'b0;
    else   cmd_valid = 1'b0;
  endtask

  // Observe nbytes frames plus gap cycles; a bit reads X unless stable for all CPB cycles.
  task automatic capture(input bit g, input int nbytes, input int gap, input bit tog,
                         output logic [29:0] fr, output bit busy_ok, output bit rdy_low,
                         output bit gap_ok);
    logic v, cur;
    fr      = '1;
    busy_ok = 1'b1;
    rdy_low = 1'b1;
    gap_ok  = 1'b1;
    cur     = 1'b0;
    for (int i = 0; i < nbytes; i++) begin
      for (int k = 0; k < 10; k++) begin
        for (int j = 0; j < CPB; j++) begin
          v = g ? g_tx : uart_tx_out;
          if (j == 0) cur = v;
          else if (v !== cur) cur = 1'bx;
          if ((g ? g_busy : busy) !== 1'b1) busy_ok = 1'b0;
          if ((g ? g_ready : cmd_ready) !== 1'b0) rdy_low = 1'b0;
          if (tog) begin cmd_valid = ~cmd_valid; cmd_op = 2'(j); cmd_col = 4'(k); end
          tick();
        end
        fr[i*10+k] = cur;
      end
    end
    for (int j = 0; j < gap; j++) begin
      if ((g ? g_tx : uart_tx_out) !== 1'b1) gap_ok = 1'b0;
      if ((g ? g_busy : busy) !== 1'b1) busy_ok = 1'b0;
      if ((g ? g_ready : cmd_ready) !== 1'b0) rdy_low = 1'b0;
      tick();
    end
    if (tog) cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    bit ok;
    bit idle_ok;
    reset = 1'b1;
    repeat (3) tick();
    n_checks++;
    if ({cmd_ready, uart_tx_out, busy} !== 3'b010) begin
      n_fail++;
      $display("FAIL reset_state ready/tx/busy=%b expected 010", {cmd_ready, uart_tx_out, busy});
    end
    reset = 1'b0;
    tick();
    n_checks++;
    if (cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release ready=%b expected 1", cmd_ready);
    end
    send(1'b0, 2'b11, 3'b000, 4'd0, 3'd0, ok);
    repeat (50) tick();
    n_checks++;
    if (uart_tx_out !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midframe_precond tx=%b busy=%b expected 0 1", uart_tx_out, busy);
    end
    reset = 1'b1;
    tick();
    n_checks++;
    if ({cmd_ready, uart_tx_out, busy} !== 3'b010) begin
      n_fail++;
      $display("FAIL midframe_reset ready/tx/busy=%b expected 010", {cmd_ready, uart_tx_out, busy});
    end
    repeat (4) tick();
    reset = 1'b0;
    tick();
    n_checks++;
    if ({cmd_ready, uart_tx_out, busy} !== 3'b110) begin
      n_fail++;
      $display("FAIL after_reset ready/tx/busy=%b expected 110", {cmd_ready, uart_tx_out, busy});
    end
    idle_ok = 1'b1;
    repeat (300) begin
      if (uart_tx_out !== 1'b1 || busy !== 1'b0) idle_ok = 1'b0;
      tick();
    end
    n_checks++;
    if (idle_ok !== 1'b1) begin
      n_fail++;
      $display("FAIL dropped_cmd line_idle=%b expected 1", idle_ok);
    end
  endtask

  task automatic test_colour();
    bit ok, b_ok, r_low, g_ok;
    logic [29:0] fr, exp;
    send(1'b0, 2'b00, 3'b101, 4'd0, 3'd0, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL colour_accept timeout got 0 expected 1"); end
    n_checks++;
    if (uart_tx_out !== 1'b0) begin
      n_fail++;
      $display("FAIL colour_start_latency tx=%b expected 0", uart_tx_out);
    end
    capture(1'b0, 1 + RS, 0, 1'b0, fr, b_ok, r_low, g_ok);
    exp = '1;
    if (RS == 1) exp[19:0] = {fr10(8'h05), fr10(8'hFF)};
    else         exp[9:0]  = fr10(8'h05);
    n_checks++;
    if (fr !== exp) begin n_fail++; $display("FAIL colour_frame got %h expected %h", fr, exp); end
    n_checks++;
    if ({b_ok, r_low} !== 2'b11) begin
      n_fail++;
      $display("FAIL colour_busy busy_ok/ready_low=%b expected 11", {b_ok, r_low});
    end
    n_checks++;
    if ({busy, cmd_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL colour_done busy/ready=%b expected 01", {busy, cmd_ready});
    end
  endtask

  task automatic test_set_pixel();
    bit ok, b_ok, r_low, g_ok;
    logic [29:0] fr, exp;
    send(1'b0, 2'b01, 3'b000, 4'd9, 3'd6, ok);
    capture(1'b0, 2 + RS, 0, 1'b0, fr, b_ok, r_low, g_ok);
    exp = '1;
    if (RS == 1) exp = {fr10(8'h96), fr10(8'h10), fr10(8'hFF)};
    else         exp[19:0] = {fr10(8'h96), fr10(8'h10)};
    n_checks++;
    if (fr !== exp) begin n_fail++; $display("FAIL set_frames got %h expected %h", fr, exp); end
    n_checks++;
    if ({b_ok, r_low} !== 2'b11) begin
      n_fail++;
      $display("FAIL set_ready_low busy_ok/ready_low=%b expected 11", {b_ok, r_low});
    end
    n_checks++;
    if ({busy, cmd_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL set_done busy/ready=%b expected 01", {busy, cmd_ready});
    end
  endtask

  task automatic test_back_to_back();
    bit ok, b_ok, r_low, g_ok;
    logic [29:0] fr, exp;
    send(1'b0, 2'b10, 3'b000, 4'd15, 3'd7, ok);
    cmd_op = 2'b11; cmd_rgb = 3'b111; cmd_col = 4'd3; cmd_row = 3'd2;
    cmd_valid = 1'b1;
    capture(1'b0, 2 + RS, 0, 1'b0, fr, b_ok, r_low, g_ok);
    exp = '1;
    if (RS == 1) exp = {fr10(8'hF7), fr10(8'h20), fr10(8'hFF)};
    else         exp[19:0] = {fr10(8'hF7), fr10(8'h20)};
    n_checks++;
    if (fr !== exp) begin n_fail++; $display("FAIL clr_frames got %h expected %h", fr, exp); end
    n_checks++;
    if ({cmd_ready, uart_tx_out, busy} !== 3'b110) begin
      n_fail++;
      $display("FAIL b2b_ready_cycle ready/tx/busy=%b expected 110", {cmd_ready, uart_tx_out, busy});
    end
    tick();
    cmd_valid = 1'b0;
    n_checks++;
    if (uart_tx_out !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_start tx=%b busy=%b expected 0 1", uart_tx_out, busy);
    end
    capture(1'b0, 1 + RS, 0, 1'b0, fr, b_ok, r_low, g_ok);
    exp = '1;
    if (RS == 1) exp[19:0] = {fr10(8'h30), fr10(8'hFF)};
    else         exp[9:0]  = fr10(8'h30);
    n_checks++;
    if (fr !== exp) begin n_fail++; $display("FAIL cls_frame got %h expected %h", fr, exp); end
  endtask

  task automatic test_gap();
    bit ok, b_ok, r_low, g_ok;
    logic [29:0] fr, exp;
    send(1'b1, 2'b11, 3'b000, 4'd0, 3'd0, ok);
    n_checks++;
    if (g_tx !== 1'b0) begin n_fail++; $display("FAIL gap_start tx=%b expected 0", g_tx); end
    // With the prefix, a gap also follows the sync byte and sits inside the next byte's frame time.
    if (RS == 1) begin
      capture(1'b1, 1, 2 * CPB, 1'b0, fr, b_ok, r_low, g_ok);
      n_checks++;
      if (fr[9:0] !== fr10(8'hFF) || g_ok !== 1'b1) begin
        n_fail++;
        $display("FAIL gap_sync got %h gap_ok=%b expected %h 1", fr[9:0], g_ok, fr10(8'hFF));
      end
    end
    capture(1'b1, 1, 2 * CPB, 1'b0, fr, b_ok, r_low, g_ok);
    exp = '1;
    exp[9:0] = fr10(8'h30);
    n_checks++;
    if (fr !== exp) begin n_fail++; $display("FAIL gap_frame got %h expected %h", fr, exp); end
    n_checks++;
    if ({b_ok, r_low, g_ok} !== 3'b111) begin
      n_fail++;
      $display("FAIL gap_idle busy_ok/ready_low/gap_high=%b expected 111", {b_ok, r_low, g_ok});
    end
    n_checks++;
    if ({g_busy, g_ready, g_tx} !== 3'b011) begin
      n_fail++;
      $display("FAIL gap_done busy/ready/tx=%b expected 011", {g_busy, g_ready, g_tx});
    end
  endtask

  task automatic test_resync();
    bit ok, b_ok, r_low, g_ok;
    logic [29:0] fr, exp;
    send(1'b0, 2'b01, 3'b000, 4'd0, 3'd0, ok);
    capture(1'b0, 2 + RS, 0, 1'b1, fr, b_ok, r_low, g_ok);
    exp = '1;
    if (RS == 1) exp = {fr10(8'h00), fr10(8'h10), fr10(8'hFF)};
    else         exp[19:0] = {fr10(8'h00), fr10(8'h10)};
    n_checks++;
    if (fr !== exp) begin n_fail++; $display("FAIL resync_frames got %h expected %h", fr, exp); end
    n_checks++;
    if ({b_ok, r_low} !== 2'b11) begin
      n_fail++;
      $display("FAIL resync_toggle busy_ok/ready_low=%b expected 11", {b_ok, r_low});
    end
    tick();
    n_checks++;
    if ({busy, cmd_ready, uart_tx_out} !== 3'b011) begin
      n_fail++;
      $display("FAIL resync_no_extra busy/ready/tx=%b expected 011", {busy, cmd_ready, uart_tx_out});
    end
  endtask

  initial begin
    reset = 1'b1;
    cmd_valid = 1'b0; cmd_op = '0; cmd_rgb = '0; cmd_col = '0; cmd_row = '0;
    g_valid = 1'b0; g_op = '0; g_rgb = '0; g_col = '0; g_row = '0;
    #1;
    test_reset();
    test_colour();
    test_set_pixel();
    test_back_to_back();
    test_gap();
    test_resync();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
